// File: rtl/cv32e40x_rf_write_queue.sv
// In-order queue of late write-back results draining into an idle register file write port,
// with youngest-entry forwarding for operand reads while writes are still pending.
module cv32e40x_rf_write_queue #(
  parameter int unsigned DEPTH                  = 4,
  parameter int unsigned REGFILE_NUM_READ_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [4:0]                 in_addr_i,
  input  logic [31:0]                in_data_i,
  input  logic                       wgrant_i,
  output logic                       we_o,
  output logic [4:0]                 waddr_o,
  output logic [31:0]                wdata_o,
  input  logic [4:0]                 raddr_i    [REGFILE_NUM_READ_PORTS],
  output logic                       fwd_hit_o  [REGFILE_NUM_READ_PORTS],
  output logic [31:0]                fwd_data_o [REGFILE_NUM_READ_PORTS],
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]    addr_q  [DEPTH];
  logic [31:0]   data_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;

  logic push;
  logic pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign in_ready_o = !full_o;
  assign count_o    = count_q;

  // x0 writes complete the handshake but are never stored
  assign push = in_valid_i && in_ready_o && (in_addr_i != 5'd0);
  assign pop  = we_o;

  assign we_o    = !empty_o && wgrant_i;
  assign waddr_o = empty_o ? 5'd0  : addr_q[rptr_q];
  assign wdata_o = empty_o ? 32'd0 : data_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      if (push) begin
        addr_q[wptr_q]  <= in_addr_i;
        data_q[wptr_q]  <= in_data_i;
        valid_q[wptr_q] <= 1'b1;
        wptr_q          <= wptr_q + PW'(1);
      end
      if (pop) begin
        valid_q[rptr_q] <= 1'b0;
        rptr_q          <= rptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Walk from head to tail so the last match found is the youngest entry
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int unsigned p = 0; p < REGFILE_NUM_READ_PORTS; p++) begin
      fwd_hit_o[p]  = 1'b0;
      fwd_data_o[p] = 32'd0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = rptr_q + PW'(i);
        if ((raddr_i[p] != 5'd0) && valid_q[idx] && (addr_q[idx] == raddr_i[p])) begin
          fwd_hit_o[p]  = 1'b1;
          fwd_data_o[p] = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_rf_write_queue.sv
// Self-checking bench for cv32e40x_rf_write_queue: directed scenarios then random traffic,
// all compared every cycle against a queue-based reference model.
module tb_cv32e40x_rf_write_queue;

  localparam int DEPTH = 4;
  localparam int NRP   = 2;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  in_addr_i;
  logic [31:0] in_data_i;
  logic        wgrant_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [4:0]  raddr_i    [NRP];
  logic        fwd_hit_o  [NRP];
  logic [31:0] fwd_data_o [NRP];
  logic [2:0]  count_o;
  logic        empty_o;
  logic        full_o;

  int n_cmp;
  int n_err;

  // Reference model: each element is {addr, data}, index 0 is the oldest
  logic [36:0] mq[$];

  cv32e40x_rf_write_queue #(.DEPTH(DEPTH), .REGFILE_NUM_READ_PORTS(NRP)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_addr_i  (in_addr_i),
    .in_data_i  (in_data_i),
    .wgrant_i   (wgrant_i),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .raddr_i    (raddr_i),
    .fwd_hit_o  (fwd_hit_o),
    .fwd_data_o (fwd_data_o),
    .count_o    (count_o),
    .empty_o    (empty_o),
    .full_o     (full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [4:0] a,
                               input logic [31:0] d, input logic g,
                               input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clk);
    rst        = r;
    in_valid_i = v;
    in_addr_i  = a;
    in_data_i  = d;
    wgrant_i   = g;
    raddr_i[0] = r0;
    raddr_i[1] = r1;
    #1;
  endtask

  task automatic checkOutput();
    int          sz;
    logic [4:0]  ra;
    logic        eh;
    logic [31:0] ed;
    sz = mq.size();
    chk("count", 32'(count_o), 32'(sz));
    chk("empty", 32'(empty_o), 32'(sz == 0));
    chk("full", 32'(full_o), 32'(sz == DEPTH));
    chk("ready", 32'(in_ready_o), 32'(sz < DEPTH));
    chk("we", 32'(we_o), 32'((sz > 0) && wgrant_i));
    chk("waddr", 32'(waddr_o), (sz > 0) ? 32'(mq[0][36:32]) : 32'd0);
    chk("wdata", wdata_o, (sz > 0) ? mq[0][31:0] : 32'd0);
    for (int p = 0; p < NRP; p++) begin
      ra = raddr_i[p];
      eh = 1'b0;
      ed = 32'd0;
      if (ra != 5'd0) begin
        for (int i = sz - 1; i >= 0; i--) begin
          if (mq[i][36:32] == ra) begin
            eh = 1'b1;
            ed = mq[i][31:0];
            break;
          end
        end
      end
      chk($sformatf("fwd_hit%0d", p), 32'(fwd_hit_o[p]), 32'(eh));
      chk($sformatf("fwd_data%0d", p), fwd_data_o[p], ed);
    end
  endtask

  // One cycle: drive, check against model, clock, then advance the model
  task automatic step(input logic r, input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic g, input logic [4:0] r0, input logic [4:0] r1, output bit acc);
    bit do_pop;
    applyStimulus(r, v, a, d, g, r0, r1);
    checkOutput();
    acc    = v && (mq.size() < DEPTH);
    do_pop = (mq.size() > 0) && g;
    @(posedge clk);
    if (r) begin
      mq.delete();
      acc = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (acc && (a != 5'd0)) mq.push_back({a, d});
    end
  endtask

  task automatic push_hold(input logic [4:0] a, input logic [31:0] d, input bit toggle_grant);
    bit acc;
    bit g;
    g = 1'b0;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      step(1'b0, 1'b1, a, d, g, a, 5'd3, acc);
      if (toggle_grant) g = !g;
    end
    chk("push_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd7, acc);
    end
    chk("drain_timeout", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid_i = 1'b0;
    in_addr_i = 5'd0;
    in_data_i = 32'd0;
    wgrant_i = 1'b0;
    raddr_i[0] = 5'd0;
    raddr_i[1] = 5'd0;
    repeat (2) @(posedge clk);
    mq.delete();

    // Reset values while idle, then single push with immediate grant
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, acc);
    step(1'b0, 1'b1, 5'd5, 32'hA5A5_0001, 1'b1, 5'd5, 5'd0, acc);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, acc);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, acc);

    // Fill with grant low, stall a fifth push, then drain in order
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0, 5'(i), 5'd2, acc);
    step(1'b0, 1'b1, 5'd5, 32'h1005, 1'b0, 5'd5, 5'd4, acc);
    chk("fifth_push_stalled", 32'(acc), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 5'd5, 32'h1005, 1'b1, 5'd5, 5'd1, acc);
      if (acc) break;
    end
    chk("fifth_push_accepted", 32'(acc), 32'd1);
    drain();

    // Two writes to the same register: youngest forwards, other port misses
    step(1'b0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd7, 5'd8, acc);
    step(1'b0, 1'b1, 5'd7, 32'h22, 1'b0, 5'd7, 5'd8, acc);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd8, acc);
    chk("fwd_youngest", fwd_data_o[0], 32'h22);
    drain();

    // x0 writes are dropped and never forwarded
    step(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 5'd0, acc);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, acc);

    // Wrap-around with toggling grant
    for (int i = 0; i < 10; i++) push_hold(5'(10 + i), 32'hC0DE_0000 + 32'(i), 1'b1);
    drain();

    // Reset with three queued entries while a push and grant are active
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'(20 + i), 32'hBEEF_0000 + 32'(i), 1'b0, 5'd20, 5'd21, acc);
    step(1'b1, 1'b1, 5'd23, 32'h5555, 1'b1, 5'd20, 5'd23, acc);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 5'd21, acc);

    // Random traffic over a narrow address range to exercise forwarding
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
